lif_neuron_array: RTL and testbench

- Parametrised, clocked successor to the single-neuron combinational LIF potential adder.
- Holds membrane potentials for NEURONS neurons in signed fixed point and accumulates incoming synaptic weights during a timestep.
- On timestep end, sweeps all neurons one per cycle: leak, threshold compare, reset (subtract-threshold or reset-to-zero), refractory handling.
- Emits spike events over a valid/ready handshake to the NoC router interface.

---
 rtl/lif_neuron_array.sv | 263 ++++++++++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron array.
// Weight events accumulate into per-neuron signed potentials while in ACCUM.
// An end-of-timestep pulse starts a sweep that evaluates one neuron per cycle
// (leak, threshold compare, reset, refractory countdown) and emits spikes over
// a valid/ready handshake. A debug port reads any potential combinationally.

module lif_neuron_array #(
    parameter int DATA_W      = 16,
    parameter int NEURONS     = 8,
    parameter int ID_W        = $clog2(NEURONS),
    parameter int REFRACT     = 1,
    parameter int THRESH_INIT = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     cfg_we,
    input  logic signed [DATA_W-1:0] cfg_threshold,
    input  logic                     cfg_mode,
    input  logic [3:0]               cfg_leak_shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ID_W-1:0]          in_id,
    input  logic signed [DATA_W-1:0] in_weight,
    input  logic                     ts_end,
    output logic                     spike_valid,
    input  logic                     spike_ready,
    output logic [ID_W-1:0]          spike_id,
    output logic                     done,
    output logic                     busy,
    input  logic [ID_W-1:0]          rd_id,
    output logic signed [DATA_W-1:0] rd_potential
);

    // Sweep index needs one extra bit so "all neurons evaluated" is a distinct value.
    localparam int KW = ID_W + 1;
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic signed [DATA_W-1:0] POT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] POT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] POT_ZERO  = {DATA_W{1'b0}};
    localparam logic signed [DATA_W-1:0] THR_RESET = DATA_W'(THRESH_INIT);
    localparam logic [KW-1:0]            K_END     = KW'(NEURONS);
    localparam logic [KW-1:0]            K_ZERO    = {KW{1'b0}};
    localparam logic [RW-1:0]            REFR_LOAD = RW'(REFRACT);
    localparam logic [RW-1:0]            REFR_ZERO = {RW{1'b0}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_FIRE  = 1'b1
    } state_t;

    // Two's complement add clamped to the representable range.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] sum;
        sum = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            sat_add = sum[DATA_W] ? POT_MIN : POT_MAX;
        end else begin
            sat_add = sum[DATA_W-1:0];
        end
    endfunction

    // Two's complement subtract clamped to the representable range.
    function automatic logic signed [DATA_W-1:0] sat_sub(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] diff;
        diff = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            sat_sub = diff[DATA_W] ? POT_MIN : POT_MAX;
        end else begin
            sat_sub = diff[DATA_W-1:0];
        end
    endfunction

    // Leak removes v >>> sh from v; the result always stays in range, and a
    // zero shift means no leak at all (not "subtract everything").
    function automatic logic signed [DATA_W-1:0] leak_of(
        input logic signed [DATA_W-1:0] v,
        input logic [3:0]               sh
    );
        if (sh == 4'd0) begin
            leak_of = v;
        end else begin
            leak_of = v - (v >>> sh);
        end
    endfunction

    // Guards against ids beyond the array when NEURONS is not a power of two.
    function automatic logic id_in_range(input logic [ID_W-1:0] id);
        id_in_range = ({{(32-ID_W){1'b0}}, id} < 32'(NEURONS));
    endfunction

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [DATA_W-1:0]  pot_q  [NEURONS];
    logic signed [DATA_W-1:0]  pot_d  [NEURONS];
    logic [RW-1:0]             refr_q [NEURONS];
    logic [RW-1:0]             refr_d [NEURONS];
    logic signed [DATA_W-1:0]  thr_q, thr_d;
    logic                      mode_q, mode_d;
    logic [3:0]                shift_q, shift_d;
    logic                      spike_valid_q, spike_valid_d;
    logic [ID_W-1:0]           spike_id_q, spike_id_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
    logic                      in_ready_q, in_ready_d;

    logic [ID_W-1:0]           k_id_s;
    logic signed [DATA_W-1:0]  v_leak_s;
    logic                      stall_s;
    logic                      in_take_s;

    assign k_id_s    = k_q[ID_W-1:0];
    assign v_leak_s  = leak_of(pot_q[k_id_s], shift_q);
    assign stall_s   = spike_valid_q & ~spike_ready;
    assign in_take_s = in_valid & in_ready_q & id_in_range(in_id)
                       & (refr_q[in_id] == REFR_ZERO);

    assign in_ready    = in_ready_q;
    assign spike_valid = spike_valid_q;
    assign spike_id    = spike_id_q;
    assign done        = done_q;
    assign busy        = busy_q;

    // Next-state for the controller, potentials, refractory counters and config.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        pot_d         = pot_q;
        refr_d        = refr_q;
        thr_d         = thr_q;
        mode_d        = mode_q;
        shift_d       = shift_q;
        spike_valid_d = spike_valid_q;
        spike_id_d    = spike_id_q;
        done_d        = 1'b0;
        busy_d        = busy_q;
        in_ready_d    = in_ready_q;

        if (clear) begin
            for (int i = 0; i < NEURONS; i++) begin
                pot_d[i]  = POT_ZERO;
                refr_d[i] = REFR_ZERO;
            end
            state_d       = ST_ACCUM;
            k_d           = K_ZERO;
            spike_valid_d = 1'b0;
            busy_d        = 1'b0;
            in_ready_d    = 1'b1;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (cfg_we) begin
                        thr_d   = cfg_threshold;
                        mode_d  = cfg_mode;
                        shift_d = cfg_leak_shift;
                    end else begin
                        thr_d   = thr_q;
                    end
                    // A weight arriving with ts_end lands before the sweep reads it.
                    if (in_take_s) begin
                        pot_d[in_id] = sat_add(pot_q[in_id], in_weight);
                    end else begin
                        pot_d[in_id] = pot_q[in_id];
                    end
                    if (ts_end) begin
                        state_d    = ST_FIRE;
                        k_d        = K_ZERO;
                        busy_d     = 1'b1;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d    = ST_ACCUM;
                    end
                end
                ST_FIRE: begin
                    if (stall_s) begin
                        // Downstream has not taken the pending spike: hold everything.
                        k_d = k_q;
                    end else begin
                        spike_valid_d = 1'b0;
                        if (k_q == K_END) begin
                            state_d    = ST_ACCUM;
                            k_d        = K_ZERO;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            in_ready_d = 1'b1;
                        end else begin
                            if (refr_q[k_id_s] != REFR_ZERO) begin
                                refr_d[k_id_s] = refr_q[k_id_s] - RW'(1);
                                pot_d[k_id_s]  = v_leak_s;
                            end else if (v_leak_s >= thr_q) begin
                                spike_valid_d  = 1'b1;
                                spike_id_d     = k_id_s;
                                refr_d[k_id_s] = REFR_LOAD;
                                pot_d[k_id_s]  = mode_q ? POT_ZERO
                                                        : sat_sub(v_leak_s, thr_q);
                            end else begin
                                pot_d[k_id_s]  = v_leak_s;
                            end
                            k_d = k_q + KW'(1);
                        end
                    end
                end
                default: begin
                    state_d       = ST_ACCUM;
                    k_d           = K_ZERO;
                    spike_valid_d = 1'b0;
                    busy_d        = 1'b0;
                    in_ready_d    = 1'b1;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to an idle, empty array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ACCUM;
            k_q           <= K_ZERO;
            for (int i = 0; i < NEURONS; i++) begin
                pot_q[i]  <= POT_ZERO;
                refr_q[i] <= REFR_ZERO;
            end
            thr_q         <= THR_RESET;
            mode_q        <= 1'b0;
            shift_q       <= 4'd0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= {ID_W{1'b0}};
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            pot_q         <= pot_d;
            refr_q        <= refr_d;
            thr_q         <= thr_d;
            mode_q        <= mode_d;
            shift_q       <= shift_d;
            spike_valid_q <= spike_valid_d;
            spike_id_q    <= spike_id_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
        end
    end

    // Debug read of any neuron's current potential.
    always_comb begin
        if (id_in_range(rd_id)) begin
            rd_potential = pot_q[rd_id];
        end else begin
            rd_potential = POT_ZERO;
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: directed scenarios plus randomized timesteps,
// all checked against a timestep-level arithmetic model of the neuron array.

module tb_lif_neuron_array;

    localparam int DATA_W      = 16;
    localparam int NEURONS     = 8;
    localparam int ID_W        = 3;
    localparam int REFRACT     = 1;
    localparam int THRESH_INIT = 100;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     clear;
    logic                     cfg_we;
    logic signed [DATA_W-1:0] cfg_threshold;
    logic                     cfg_mode;
    logic [3:0]               cfg_leak_shift;
    logic                     in_valid;
    logic                     in_ready;
    logic [ID_W-1:0]          in_id;
    logic signed [DATA_W-1:0] in_weight;
    logic                     ts_end;
    logic                     spike_valid;
    logic                     spike_ready;
    logic [ID_W-1:0]          spike_id;
    logic                     done;
    logic                     busy;
    logic [ID_W-1:0]          rd_id;
    logic signed [DATA_W-1:0] rd_potential;

    lif_neuron_array #(
        .DATA_W(DATA_W), .NEURONS(NEURONS), .ID_W(ID_W),
        .REFRACT(REFRACT), .THRESH_INIT(THRESH_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode),
        .cfg_leak_shift(cfg_leak_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_weight(in_weight),
        .ts_end(ts_end),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_id(spike_id),
        .done(done), .busy(busy),
        .rd_id(rd_id), .rd_potential(rd_potential)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_pot  [NEURONS];
    int m_refr [NEURONS];
    int m_thr, m_mode, m_shift;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Leak: subtract floor(v / 2^s); no leak when s is 0.
    function automatic int leak_m(input int v, input int s);
        int d, q;
        if (s == 0) return v;
        d = 1 << s;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return v - q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NEURONS; i++) begin m_pot[i] = 0; m_refr[i] = 0; end
        m_thr = THRESH_INIT; m_mode = 0; m_shift = 0;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; cfg_we = 1'b0; cfg_threshold = '0; cfg_mode = 1'b0;
        cfg_leak_shift = 4'd0; in_valid = 1'b0; in_id = '0; in_weight = '0;
        ts_end = 1'b0; spike_ready = 1'b1; rd_id = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_pots(input string tag);
        for (int i = 0; i < NEURONS; i++) begin
            rd_id = ID_W'(i);
            #1;
            check_val($sformatf("%s_pot%0d", tag, i), rd_potential, m_pot[i]);
        end
    endtask

    task automatic cfg(input int thr, input int mode, input int sh);
        cfg_we = 1'b1; cfg_threshold = 16'(thr); cfg_mode = 1'(mode);
        cfg_leak_shift = 4'(sh);
        tick();
        cfg_we = 1'b0;
        m_thr = thr; m_mode = mode; m_shift = sh;
    endtask

    task automatic weight(input int id, input int w);
        in_valid = 1'b1; in_id = ID_W'(id); in_weight = 16'(w);
        check_val("in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        if (m_refr[id] == 0) m_pot[id] = sat(m_pot[id] + w);
    endtask

    // One full timestep end: optional weight alongside ts_end, then the sweep.
    task automatic run_sweep(input bit with_w, input int wid, input int w,
                             input int hold_first, input bit rnd,
                             output int nspk, output int edges);
        int  exp_q[$];
        int  stalls, held, v;
        bit  got_done, rdy;
        nspk = 0; edges = 0; stalls = 0; held = 0; got_done = 1'b0; rdy = 1'b1;
        if (with_w) begin
            in_valid = 1'b1; in_id = ID_W'(wid); in_weight = 16'(w);
            if (m_refr[wid] == 0) m_pot[wid] = sat(m_pot[wid] + w);
        end
        ts_end = 1'b1;
        for (int k = 0; k < NEURONS; k++) begin
            v = leak_m(m_pot[k], m_shift);
            if (m_refr[k] != 0) begin
                m_refr[k] = m_refr[k] - 1;
                m_pot[k]  = v;
            end else if (v >= m_thr) begin
                exp_q.push_back(k);
                m_refr[k] = REFRACT;
                m_pot[k]  = (m_mode != 0) ? 0 : sat(v - m_thr);
            end else begin
                m_pot[k] = v;
            end
        end
        tick();
        ts_end = 1'b0; in_valid = 1'b0;
        while (!got_done && edges < 300) begin
            tick();
            edges++;
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (edges == 1) check_val("sweep_busy", busy, 1);
                if (spike_valid) begin
                    if (exp_q.size() == 0) begin
                        check_val("spike_extra", spike_id, -1);
                        rdy = 1'b1;
                    end else begin
                        check_val("spike_id", spike_id, exp_q[0]);
                        if (held < hold_first) begin
                            rdy = 1'b0; held++;
                        end else begin
                            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                        end
                        if (rdy) begin
                            void'(exp_q.pop_front());
                            nspk++;
                        end
                    end
                    if (!rdy) stalls++;
                end else begin
                    rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                spike_ready = rdy;
                if (rnd) begin
                    // Inputs that must be ignored while sweeping.
                    ts_end         = ($urandom_range(0, 3) == 0);
                    cfg_we         = ($urandom_range(0, 3) == 0);
                    cfg_threshold  = 16'($urandom);
                    cfg_mode       = 1'($urandom_range(0, 1));
                    cfg_leak_shift = 4'($urandom_range(0, 15));
                    in_valid       = ($urandom_range(0, 1) == 1);
                    in_id          = ID_W'($urandom_range(0, NEURONS - 1));
                    in_weight      = 16'($urandom);
                end
            end
        end
        idle_inputs();
        check_val("done_seen", got_done, 1);
        check_val("done_latency", edges, NEURONS + 1 + stalls);
        check_val("spikes_left", exp_q.size(), 0);
        check_val("busy_after", busy, 0);
        check_val("in_ready_after", in_ready, 1);
        check_val("spike_valid_after", spike_valid, 0);
        tick();
        check_val("done_pulse", done, 0);
        check_all_pots("sw");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nspk, edges, id, w;
        bit seen;

        // Reset values and asynchronous reset in the middle of a sweep
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_spike_valid", spike_valid, 0);
        check_val("rst_done", done, 0);
        check_all_pots("rst");
        weight(0, 150);
        weight(4, 120);
        ts_end = 1'b1; spike_ready = 1'b0;
        tick();
        ts_end = 1'b0;
        tick(); tick(); tick();
        check_val("mid_busy", busy, 1);
        check_val("mid_spike_valid", spike_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_busy", busy, 0);
        check_val("async_spike_valid", spike_valid, 0);
        check_val("async_done", done, 0);
        check_all_pots("async");
        @(posedge clk);
        #1 rst_n = 1'b1; spike_ready = 1'b1;
        tick();
        check_val("rel_in_ready", in_ready, 1);
        check_val("rel_busy", busy, 0);

        // LIF fire mode 0 and sub-threshold leak
        cfg(100, 0, 2);
        weight(1, 80); weight(1, 60);
        weight(2, 70); weight(2, 60);
        run_sweep(1'b0, 0, 0, 0, 1'b0, nspk, edges);
        check_val("lif_nspk", nspk, 1);
        check_val("lif_latency", edges, NEURONS + 1);
        rd_id = 3'd1; #1; check_val("lif_pot1", rd_potential, 5);
        rd_id = 3'd2; #1; check_val("leak_pot2", rd_potential, 98);

        // Mode 1 with a weight landing in the ts_end cycle; id 1 refractory
        cfg(100, 1, 2);
        weight(1, 200);
        weight(3, 80);
        run_sweep(1'b1, 3, 60, 0, 1'b0, nspk, edges);
        check_val("mode1_nspk", nspk, 1);
        rd_id = 3'd3; #1; check_val("mode1_pot3", rd_potential, 0);
        rd_id = 3'd1; #1; check_val("refr_pot1", rd_potential, 4);

        // Refractory over: weight accepted and id 1 fires
        weight(1, 200);
        run_sweep(1'b0, 0, 0, 0, 1'b0, nspk, edges);
        check_val("refr_end_nspk", nspk, 1);
        rd_id = 3'd1; #1; check_val("refr_end_pot1", rd_potential, 0);

        // Clear in the middle of a sweep
        cfg(100, 0, 0);
        weight(2, 300); weight(5, 50); weight(6, 500);
        ts_end = 1'b1; spike_ready = 1'b1;
        tick();
        ts_end = 1'b0;
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < NEURONS; i++) begin m_pot[i] = 0; m_refr[i] = 0; end
        check_val("clr_in_ready", in_ready, 1);
        check_val("clr_busy", busy, 0);
        check_val("clr_spike_valid", spike_valid, 0);
        check_all_pots("clr");
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (done) seen = 1'b1;
        end
        check_val("clr_no_done", seen, 0);
        weight(5, 100);
        run_sweep(1'b0, 0, 0, 0, 1'b0, nspk, edges);
        check_val("clr_thr_kept", nspk, 1);

        // Saturation and backpressure
        weight(0, 30000); weight(0, 2760); weight(0, 100);
        rd_id = 3'd0; #1; check_val("sat_hi", rd_potential, 32767);
        weight(6, -30000); weight(6, -30000);
        rd_id = 3'd6; #1; check_val("sat_lo", rd_potential, -32768);
        run_sweep(1'b0, 0, 0, 3, 1'b0, nspk, edges);
        check_val("bp_nspk", nspk, 1);
        check_val("bp_latency", edges, NEURONS + 4);

        // Randomized timesteps
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) == 0)
                cfg(int'($urandom_range(0, 400)) - 100, int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)));
            for (int n = int'($urandom_range(0, 6)); n > 0; n--) begin
                id = int'($urandom_range(0, NEURONS - 1));
                if ($urandom_range(0, 7) == 0) w = int'($urandom_range(0, 40000)) - 20000;
                else w = int'($urandom_range(0, 400)) - 150;
                weight(id, w);
            end
            id = int'($urandom_range(0, NEURONS - 1));
            w  = int'($urandom_range(0, 400)) - 150;
            run_sweep(1'($urandom_range(0, 1)), id, w, 0, 1'b1, nspk, edges);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
